// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control encodings: opcodes, funcs, select encodings, FSM states
// and instruction classes. Also imported by the datapath and alu_control.
package mips_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funcs that need their own sequencing
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MULT = 6'b011000;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_IMM = 2'b11;

  // regDst
  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  // regWriteDataSrc
  localparam logic [1:0] WDS_ALU = 2'b00;
  localparam logic [1:0] WDS_LO  = 2'b01;
  localparam logic [1:0] WDS_HI  = 2'b10;
  localparam logic [1:0] WDS_LUI = 2'b11;

  // jump
  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_TGT = 2'b01;
  localparam logic [1:0] JMP_RS  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_ALU_WB, S_BRANCH, S_JUMP, S_MULT, S_SPEC_WB, S_ILLEGAL
  } state_e;

  typedef enum logic [3:0] {
    CL_RALU, CL_LOAD, CL_STORE, CL_IMM, CL_BR, CL_JMP, CL_JR,
    CL_JAL, CL_MULT, CL_MFHI, CL_MFLO, CL_LUI, CL_ILL
  } iclass_e;

  // Full control bundle, in port order
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       bne;
    logic       link;
    logic       mult_load;
    logic [1:0] wd_src;
    logic [1:0] jump;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_instr_class.sv
// Opcode/func to instruction-class decoder shared by next-state and output logic.
module mc_instr_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output iclass_e    cls
);

  // Unknown opcodes fall through to CL_ILL; unknown R funcs are plain ALU ops
  always_comb begin
    cls = CL_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_JR:   cls = CL_JR;
          FN_MULT: cls = CL_MULT;
          FN_MFHI: cls = CL_MFHI;
          FN_MFLO: cls = CL_MFLO;
          default: cls = CL_RALU;
        endcase
      end
      OP_LW:   cls = CL_LOAD;
      OP_SW:   cls = CL_STORE;
      OP_ADDI: cls = CL_IMM;
      OP_SLTI: cls = CL_IMM;
      OP_BEQ:  cls = CL_BR;
      OP_BNE:  cls = CL_BR;
      OP_J:    cls = CL_JMP;
      OP_JAL:  cls = CL_JAL;
      OP_LUI:  cls = CL_LUI;
      default: cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/... and decodes the
// control bundle from the state and the IR fields.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instOpcode,
  input  logic [5:0] instFunc,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       irWrite,
  output logic [1:0] regDst,
  output logic [1:0] ALUOp,
  output logic       ALUSrc,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic       branch,
  output logic       bne,
  output logic       link,
  output logic       multLoad,
  output logic [1:0] regWriteDataSrc,
  output logic [1:0] jump,
  output logic       illegal
);

  state_e  state_q, state_d;
  iclass_e cls;
  ctrl_t   ctl;
  logic    alu_src_x;
  logic [1:0] alu_op_x;

  // zero is consumed by the datapath alongside branch/bne, not here
  logic zero_unused;
  assign zero_unused = zero;

  mc_instr_class u_class (
    .opcode (instOpcode),
    .func   (instFunc),
    .cls    (cls)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (cls)
          CL_RALU, CL_LOAD, CL_STORE, CL_IMM: state_d = S_EXEC;
          CL_BR:                              state_d = S_BRANCH;
          CL_JMP, CL_JAL, CL_JR:              state_d = S_JUMP;
          CL_MULT:                            state_d = S_MULT;
          CL_MFHI, CL_MFLO, CL_LUI:           state_d = S_SPEC_WB;
          default:                            state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC: begin
        if (cls == CL_LOAD)       state_d = S_MEM_RD;
        else if (cls == CL_STORE) state_d = S_MEM_WR;
        else                      state_d = S_ALU_WB;
      end
      S_MEM_RD: if (memReady) state_d = S_MEM_WB;
      S_MEM_WR: if (memReady) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // EXEC-phase ALU controls, reused by every state that holds them
  always_comb begin
    alu_src_x = 1'b0;
    alu_op_x  = ALUOP_R;
    case (cls)
      CL_LOAD, CL_STORE: begin alu_src_x = 1'b1; alu_op_x = ALUOP_ADD; end
      CL_IMM:            begin alu_src_x = 1'b1; alu_op_x = ALUOP_IMM; end
      default:           begin alu_src_x = 1'b0; alu_op_x = ALUOP_R;   end
    endcase
  end

  // Output decode; reset forces the whole bundle low so nothing commits
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: ctl.ir_write = 1'b1;
      S_EXEC: begin
        ctl.alu_src = alu_src_x;
        ctl.alu_op  = alu_op_x;
      end
      S_MEM_RD: begin
        ctl.alu_src  = alu_src_x;
        ctl.alu_op   = alu_op_x;
        ctl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctl.alu_src    = 1'b1;
        ctl.alu_op     = ALUOP_ADD;
        ctl.mem_read   = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = RDST_RT;
        ctl.pc_write   = 1'b1;
      end
      S_MEM_WR: begin
        ctl.alu_src   = 1'b1;
        ctl.alu_op    = ALUOP_ADD;
        ctl.mem_write = 1'b1;
        ctl.pc_write  = memReady;
      end
      S_ALU_WB: begin
        ctl.alu_src   = alu_src_x;
        ctl.alu_op    = alu_op_x;
        ctl.reg_write = 1'b1;
        ctl.pc_write  = 1'b1;
        ctl.reg_dst   = (cls == CL_RALU) ? RDST_RD : RDST_RT;
      end
      S_BRANCH: begin
        ctl.alu_op   = ALUOP_SUB;
        ctl.branch   = (instOpcode == OP_BEQ);
        ctl.bne      = (instOpcode == OP_BNE);
        ctl.pc_write = 1'b1;
      end
      S_JUMP: begin
        ctl.jump     = (cls == CL_JR) ? JMP_RS : JMP_TGT;
        ctl.pc_write = 1'b1;
        if (cls == CL_JAL) begin
          ctl.link      = 1'b1;
          ctl.reg_dst   = RDST_RA;
          ctl.reg_write = 1'b1;
        end
      end
      S_MULT: begin
        ctl.mult_load = 1'b1;
        ctl.pc_write  = 1'b1;
      end
      S_SPEC_WB: begin
        ctl.reg_write = 1'b1;
        ctl.pc_write  = 1'b1;
        case (cls)
          CL_MFHI: begin ctl.reg_dst = RDST_RD; ctl.wd_src = WDS_HI;  end
          CL_MFLO: begin ctl.reg_dst = RDST_RD; ctl.wd_src = WDS_LO;  end
          default: begin ctl.reg_dst = RDST_RT; ctl.wd_src = WDS_LUI; end
        endcase
      end
      S_ILLEGAL: begin
        ctl.pc_write = 1'b1;
        ctl.illegal  = 1'b1;
      end
      default: ctl = '0;
    endcase
    if (rst) ctl = '0;
  end

  assign pcWrite         = ctl.pc_write;
  assign irWrite         = ctl.ir_write;
  assign regDst          = ctl.reg_dst;
  assign ALUOp           = ctl.alu_op;
  assign ALUSrc          = ctl.alu_src;
  assign memRead         = ctl.mem_read;
  assign memWrite        = ctl.mem_write;
  assign memToReg        = ctl.mem_to_reg;
  assign regWrite        = ctl.reg_write;
  assign branch          = ctl.branch;
  assign bne             = ctl.bne;
  assign link            = ctl.link;
  assign multLoad        = ctl.mult_load;
  assign regWriteDataSrc = ctl.wd_src;
  assign jump            = ctl.jump;
  assign illegal         = ctl.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: every cycle compares the full 20-bit control bundle against
// a hand-built expected vector.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] instOpcode, instFunc;
  logic       zero, memReady;
  logic       pcWrite, irWrite, ALUSrc, memRead, memWrite, memToReg, regWrite;
  logic       branch, bne, link, multLoad, illegal;
  logic [1:0] regDst, ALUOp, regWriteDataSrc, jump;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .instOpcode(instOpcode), .instFunc(instFunc),
    .zero(zero), .memReady(memReady), .pcWrite(pcWrite), .irWrite(irWrite),
    .regDst(regDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .memRead(memRead),
    .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite),
    .branch(branch), .bne(bne), .link(link), .multLoad(multLoad),
    .regWriteDataSrc(regWriteDataSrc), .jump(jump), .illegal(illegal)
  );

  // Bundle layout: pcW irW regDst[2] ALUOp[2] ALUSrc mRd mWr m2r rW br bne lnk mul wds[2] jmp[2] ill
  logic [19:0] ctl;
  assign ctl = {pcWrite, irWrite, regDst, ALUOp, ALUSrc, memRead, memWrite, memToReg,
                regWrite, branch, bne, link, multLoad, regWriteDataSrc, jump, illegal};

  localparam logic [19:0] NONE  = 20'h0;
  localparam logic [19:0] PCW   = 20'h1 << 19;
  localparam logic [19:0] IRW   = 20'h1 << 18;
  localparam logic [19:0] RD_RD = 20'h1 << 16;
  localparam logic [19:0] RD_31 = 20'h2 << 16;
  localparam logic [19:0] A_SUB = 20'h1 << 14;
  localparam logic [19:0] A_R   = 20'h2 << 14;
  localparam logic [19:0] A_I   = 20'h3 << 14;
  localparam logic [19:0] ASRC  = 20'h1 << 13;
  localparam logic [19:0] MRD   = 20'h1 << 12;
  localparam logic [19:0] MWR   = 20'h1 << 11;
  localparam logic [19:0] M2R   = 20'h1 << 10;
  localparam logic [19:0] RW    = 20'h1 << 9;
  localparam logic [19:0] BR    = 20'h1 << 8;
  localparam logic [19:0] BNE   = 20'h1 << 7;
  localparam logic [19:0] LNK   = 20'h1 << 6;
  localparam logic [19:0] MUL   = 20'h1 << 5;
  localparam logic [19:0] W_LO  = 20'h1 << 3;
  localparam logic [19:0] W_HI  = 20'h2 << 3;
  localparam logic [19:0] W_LUI = 20'h3 << 3;
  localparam logic [19:0] J_T   = 20'h1 << 1;
  localparam logic [19:0] J_RS  = 20'h2 << 1;
  localparam logic [19:0] ILL   = 20'h1;

  // Advance one cycle; inputs are then changed and outputs sampled mid-cycle
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [19:0] e);
    #1;
    checks++;
    assert (ctl === e) else begin
      errors++;
      $error("FAIL %s observed %05h expected %05h", tag, ctl, e);
    end
  endtask

  // Check the current cycle, then move to the next one
  task automatic step(input string tag, input logic [19:0] e);
    chk(tag, e);
    tick();
  endtask

  task automatic set_inst(input logic [5:0] op, input logic [5:0] fn);
    instOpcode = op;
    instFunc   = fn;
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; memReady = 1'b0;
    set_inst(6'b000000, 6'b100000);
    tick();
    step("reset0", NONE);
    step("reset1", NONE);
    rst = 1'b0;

    // add, interrupted by reset in EXEC
    step("add_fetch", IRW);
    step("add_decode", NONE);
    chk("add_exec", A_R);
    rst = 1'b1; zero = 1'b1;
    step("rst_exec0", NONE);
    step("rst_exec1", NONE);
    step("rst_exec2", NONE);
    chk("rst_exec3", NONE);
    rst = 1'b0; zero = 1'b0;

    // add, complete
    step("add_fetch2", IRW);
    step("add_decode2", NONE);
    step("add_exec2", A_R);
    step("add_wb", PCW | RD_RD | A_R | RW);

    // lw with two wait states
    set_inst(6'b100011, 6'b000000);
    step("lw_fetch", IRW);
    step("lw_decode", NONE);
    step("lw_exec", ASRC);
    step("lw_mem0", ASRC | MRD);
    step("lw_mem1", ASRC | MRD);
    memReady = 1'b1;
    step("lw_mem2", ASRC | MRD);
    memReady = 1'b0;
    step("lw_wb", PCW | ASRC | MRD | M2R | RW);

    // sw, memReady high throughout (ignored outside MEM_WR)
    set_inst(6'b101011, 6'b000000);
    memReady = 1'b1;
    step("sw_fetch", IRW);
    step("sw_decode", NONE);
    step("sw_exec", ASRC);
    step("sw_mem", PCW | ASRC | MWR);

    // sw with one wait state
    memReady = 1'b0;
    step("sw1_fetch", IRW);
    step("sw1_decode", NONE);
    step("sw1_exec", ASRC);
    step("sw1_wait", ASRC | MWR);
    memReady = 1'b1;
    step("sw1_mem", PCW | ASRC | MWR);
    memReady = 1'b0;

    // beq, bne, jal, jr
    set_inst(6'b000100, 6'b000000);
    step("beq_fetch", IRW);
    step("beq_decode", NONE);
    step("beq_br", PCW | A_SUB | BR);
    set_inst(6'b000101, 6'b000000);
    step("bne_fetch", IRW);
    step("bne_decode", NONE);
    step("bne_br", PCW | A_SUB | BNE);
    set_inst(6'b000011, 6'b000000);
    step("jal_fetch", IRW);
    step("jal_decode", NONE);
    step("jal_jump", PCW | J_T | LNK | RD_31 | RW);
    set_inst(6'b000000, 6'b001000);
    step("jr_fetch", IRW);
    step("jr_decode", NONE);
    step("jr_jump", PCW | J_RS);

    // mult, mflo, illegal opcode
    set_inst(6'b000000, 6'b011000);
    step("mult_fetch", IRW);
    step("mult_decode", NONE);
    step("mult_load", PCW | MUL);
    set_inst(6'b000000, 6'b010010);
    step("mflo_fetch", IRW);
    step("mflo_decode", NONE);
    step("mflo_wb", PCW | RW | RD_RD | W_LO);
    set_inst(6'b111111, 6'b000000);
    step("ill_fetch", IRW);
    step("ill_decode", NONE);
    step("ill_retire", PCW | ILL);

    // remaining classes: addi, slti, lui, j, mfhi
    set_inst(6'b001000, 6'b000000);
    step("addi_fetch", IRW);
    step("addi_decode", NONE);
    step("addi_exec", ASRC | A_I);
    step("addi_wb", PCW | ASRC | A_I | RW);
    set_inst(6'b001010, 6'b000000);
    step("slti_fetch", IRW);
    step("slti_decode", NONE);
    step("slti_exec", ASRC | A_I);
    step("slti_wb", PCW | ASRC | A_I | RW);
    set_inst(6'b001111, 6'b000000);
    step("lui_fetch", IRW);
    step("lui_decode", NONE);
    step("lui_wb", PCW | RW | W_LUI);
    set_inst(6'b000010, 6'b000000);
    step("j_fetch", IRW);
    step("j_decode", NONE);
    step("j_jump", PCW | J_T);
    set_inst(6'b000000, 6'b010000);
    step("mfhi_fetch", IRW);
    step("mfhi_decode", NONE);
    step("mfhi_wb", PCW | RW | RD_RD | W_HI);
    chk("final_fetch", IRW);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
